// File: rtl/pe_dot_product_pkg.sv
// Shared definitions for the lane-serial dot-product processing element:
// default geometry and the FSM state encoding.
package pe_dot_product_pkg;

  localparam int DefMaxWidth  = 9;
  localparam int DefDataWidth = 8;
  localparam int DefAccWidth  = 32;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMac  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  typedef enum logic [1:0] {
    IDLE = StIdle,
    MAC  = StMac,
    DONE = StDone
  } peState_e;

endpackage

// File: rtl/pe_dot_product_mac_lane.sv
// One multiply-accumulate step: signed lane product added to the running sum,
// clamped to the signed accumulator range with an overflow flag.
module pe_mac_lane #(
  parameter int DataWidth = 8,
  parameter int AccWidth  = 32
) (
  input  logic signed [DataWidth-1:0] act,
  input  logic signed [DataWidth-1:0] wgt,
  input  logic signed [AccWidth-1:0]  accIn,
  output logic signed [AccWidth-1:0]  accOut,
  output logic                        ovf
);

  localparam logic signed [AccWidth-1:0] AccMax = {1'b0, {(AccWidth-1){1'b1}}};
  localparam logic signed [AccWidth-1:0] AccMin = {1'b1, {(AccWidth-1){1'b0}}};

  logic signed [2*DataWidth-1:0] prod;
  logic signed [AccWidth:0]      sum;

  always_comb begin
    prod = act * wgt;
    sum  = (AccWidth+1)'(accIn) + (AccWidth+1)'(prod);
    // One guard bit: the sum left the range when it disagrees with the old sign bit.
    ovf  = sum[AccWidth] ^ sum[AccWidth-1];
    if (ovf) begin
      accOut = sum[AccWidth] ? AccMin : AccMax;
    end else begin
      accOut = sum[AccWidth-1:0];
    end
  end

endmodule

// File: rtl/pe_dot_product.sv
// Lane-serial dot-product engine: accepts an activation/weight vector pair,
// accumulates one lane per cycle and presents the saturated group sum.
module pe_dot_product
  import pe_dot_product_pkg::*;
#(
  parameter int MaxWidth  = DefMaxWidth,
  parameter int DataWidth = DefDataWidth,
  parameter int AccWidth  = DefAccWidth
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic                            inLast,
  input  logic [MaxWidth*DataWidth-1:0]   actIn,
  input  logic [MaxWidth*DataWidth-1:0]   wgtIn,
  output logic                            outValid,
  input  logic                            outReady,
  output logic [AccWidth-1:0]             result,
  output logic                            overflow
);

  localparam int LaneBits = (MaxWidth > 1) ? $clog2(MaxWidth) : 1;
  localparam int VecBits  = MaxWidth * DataWidth;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits for ready, and ready/valid are registered.
  peState_e               state, nextState;
  logic [VecBits-1:0]     actReg, wgtReg;
  logic                   lastReg;
  logic [LaneBits-1:0]    laneCnt;
  logic signed [AccWidth-1:0] acc, laneAcc;
  logic                   ovfReg, laneOvf;
  logic [DataWidth-1:0]   actLane, wgtLane;
  logic                   accept, take, lastLane;

  assign accept   = inValid & inReady;
  assign take     = outValid & outReady;
  assign lastLane = (laneCnt == LaneBits'(MaxWidth - 1));
  assign result   = acc;
  assign overflow = ovfReg;

  always_comb begin
    actLane = actReg[int'(laneCnt)*DataWidth +: DataWidth];
    wgtLane = wgtReg[int'(laneCnt)*DataWidth +: DataWidth];
  end

  pe_mac_lane #(
    .DataWidth(DataWidth),
    .AccWidth (AccWidth)
  ) uMacLane (
    .act   (actLane),
    .wgt   (wgtLane),
    .accIn (acc),
    .accOut(laneAcc),
    .ovf   (laneOvf)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = MAC;
      MAC:     if (lastLane) nextState = lastReg ? DONE : IDLE;
      DONE:    if (take) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      inReady  <= 1'b0;
      outValid <= 1'b0;
      actReg   <= '0;
      wgtReg   <= '0;
      lastReg  <= 1'b0;
      laneCnt  <= '0;
      acc      <= '0;
      ovfReg   <= 1'b0;
    end else begin
      state    <= nextState;
      inReady  <= (nextState == IDLE);
      // DONE is entered one edge before the result is offered.
      outValid <= (state == DONE) && !take;
      case (state)
        IDLE: begin
          if (accept) begin
            actReg  <= actIn;
            wgtReg  <= wgtIn;
            lastReg <= inLast;
            laneCnt <= '0;
          end
        end
        MAC: begin
          acc     <= laneAcc;
          ovfReg  <= ovfReg | laneOvf;
          laneCnt <= laneCnt + 1'b1;
        end
        DONE: begin
          if (take) begin
            acc    <= '0;
            ovfReg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_dot_product.sv
// Bench for pe_dot_product: a 32-bit and a 16-bit accumulator instance run in
// lockstep on shared stimulus and are checked against an arithmetic model.
module tb_pe_dot_product;

  localparam int MW = 9;
  localparam int DW = 8;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic rst;
  logic inValid, inLast, outReady;
  logic [MW*DW-1:0] actIn, wgtIn;
  logic        inReadyA, outValidA, ovfA;
  logic [31:0] resA;
  logic        inReadyB, outValidB, ovfB;
  logic [15:0] resB;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pe_dot_product #(.MaxWidth(MW), .DataWidth(DW), .AccWidth(32)) dutA (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReadyA), .inLast(inLast),
    .actIn(actIn), .wgtIn(wgtIn), .outValid(outValidA), .outReady(outReady),
    .result(resA), .overflow(ovfA)
  );

  pe_dot_product #(.MaxWidth(MW), .DataWidth(DW), .AccWidth(16)) dutB (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReadyB), .inLast(inLast),
    .actIn(actIn), .wgtIn(wgtIn), .outValid(outValidB), .outReady(outReady),
    .result(resB), .overflow(ovfB)
  );

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;
  logic [32:0] exp_a_q[$];
  logic [16:0] exp_b_q[$];
  longint m_acc[2];
  bit     m_ovf[2];
  int     va[MW];
  int     vw[MW];
  int     acc_edge;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      m_acc[u] = 0;
      m_ovf[u] = 1'b0;
    end
  endtask

  // Saturating dot product straight from the arithmetic rules.
  task automatic model_pair(input bit last);
    for (int u = 0; u < 2; u++) begin
      int w;
      longint hi, lo, s;
      w  = (u == 0) ? 32 : 16;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -hi - 1;
      for (int k = 0; k < MW; k++) begin
        s = m_acc[u] + longint'(va[k] * vw[k]);
        if (s > hi) begin s = hi; m_ovf[u] = 1'b1; end
        else if (s < lo) begin s = lo; m_ovf[u] = 1'b1; end
        m_acc[u] = s;
      end
    end
    if (last) begin
      exp_a_q.push_back({m_ovf[0], 32'(m_acc[0])});
      exp_b_q.push_back({m_ovf[1], 16'(m_acc[1])});
      model_clear();
    end
  endtask

  task automatic scramble_bus();
    for (int k = 0; k < MW; k++) begin
      actIn[k*DW +: DW] = DW'($urandom);
      wgtIn[k*DW +: DW] = DW'($urandom);
    end
    inLast = 1'($urandom);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_pair(input bit last);
    int n;
    n = 0;
    @(negedge clk);
    chk("no_early_valid", {63'd0, outValidA}, 64'sd0);
    for (int k = 0; k < MW; k++) begin
      actIn[k*DW +: DW] = DW'(va[k]);
      wgtIn[k*DW +: DW] = DW'(vw[k]);
    end
    inLast  = last;
    inValid = 1'b1;
    while (!inReadyA && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", {63'd0, inReadyA}, 64'sd1);
      inValid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    inValid  = 1'b0;
    acc_edge = cyc;
    scramble_bus();
    chk("inReady_low_after_accept", {63'd0, inReadyA}, 64'sd0);
    model_pair(last);
  endtask

  task automatic get_result(input int stall);
    int n;
    logic [32:0] ea;
    logic [16:0] eb;
    n = 0;
    while (!outValidA && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("outValid_timeout", {63'd0, outValidA}, 64'sd1);
      return;
    end
    if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
      chk("unexpected_result", {63'd0, outValidA}, 64'sd0);
      return;
    end
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    chk("latency", 64'(cyc - acc_edge), 64'(MW + 1));
    chk("outValid16", {63'd0, outValidB}, 64'sd1);
    chk("result32", $signed(resA), $signed(ea[31:0]));
    chk("overflow32", {63'd0, ovfA}, {63'd0, ea[32]});
    chk("result16", $signed(resB), $signed(eb[15:0]));
    chk("overflow16", {63'd0, ovfB}, {63'd0, eb[16]});
    for (int s = 0; s < stall; s++) begin
      outReady = 1'b0;
      inValid  = 1'b1;
      scramble_bus();
      @(negedge clk);
      chk("stall_result32", $signed(resA), $signed(ea[31:0]));
      chk("stall_result16", $signed(resB), $signed(eb[15:0]));
      chk("stall_inReady", {63'd0, inReadyA}, 64'sd0);
      chk("stall_outValid", {63'd0, outValidA}, 64'sd1);
    end
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    inValid  = 1'b0;
    chk("outValid_cleared", {63'd0, outValidA}, 64'sd0);
    chk("inReady_after_take", {63'd0, inReadyA}, 64'sd1);
    chk("result_cleared", $signed(resA), 64'sd0);
  endtask

  task automatic fill(input int a, input int w);
    for (int k = 0; k < MW; k++) begin
      va[k] = a;
      vw[k] = w;
    end
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int k = 0; k < MW; k++) begin
      va[k] = int'($urandom_range(hi - lo)) + lo;
      vw[k] = int'($urandom_range(hi - lo)) + lo;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e1;
    rst = 1'b1; inValid = 1'b0; inLast = 1'b0; outReady = 1'b0;
    actIn = '0; wgtIn = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_inReady", {63'd0, inReadyA}, 64'sd0);
    chk("reset_outValid", {63'd0, outValidA}, 64'sd0);
    chk("reset_result", $signed(resA), 64'sd0);
    chk("reset_overflow", {63'd0, ovfA}, 64'sd0);
    rst = 1'b0;
    @(negedge clk);
    chk("inReady_after_reset", {63'd0, inReadyA}, 64'sd1);

    // Ramp activations against unit weights.
    for (int k = 0; k < MW; k++) begin va[k] = k + 1; vw[k] = 1; end
    send_pair(1'b1);
    get_result(0);

    // Most negative products: large negative sum, saturates at 16 bits.
    fill(-128, 127);
    send_pair(1'b1);
    get_result(0);

    // Two-pair group, one result after the second.
    fill(2, 3);
    send_pair(1'b0);
    e1 = acc_edge;
    send_pair(1'b1);
    chk("pair_throughput", 64'(acc_edge - e1), 64'(MW + 1));
    get_result(0);

    // Positive saturation at 16 bits, then a clean small group.
    fill(127, 127);
    send_pair(1'b1);
    get_result(0);
    fill_random(-3, 3);
    send_pair(1'b1);
    get_result(0);

    // Consumer stall with new pairs offered.
    fill_random(-128, 127);
    send_pair(1'b1);
    get_result(5);
    fill_random(-128, 127);
    send_pair(1'b1);
    get_result(0);

    // Reset in the middle of accumulation.
    fill(100, 100);
    send_pair(1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_inReady", {63'd0, inReadyA}, 64'sd0);
    chk("midrst_outValid", {63'd0, outValidA}, 64'sd0);
    chk("midrst_result32", $signed(resA), 64'sd0);
    chk("midrst_result16", $signed(resB), 64'sd0);
    chk("midrst_overflow", {63'd0, ovfA | ovfB}, 64'sd0);
    exp_a_q.delete();
    exp_b_q.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_inReady_rise", {63'd0, inReadyA}, 64'sd1);
    for (int k = 0; k < MW; k++) begin va[k] = k + 1; vw[k] = 1; end
    send_pair(1'b1);
    get_result(0);

    // Randomised groups of one to three pairs.
    for (int g = 0; g < 8; g++) begin
      int len;
      len = int'($urandom_range(1, 3));
      for (int p = 0; p < len; p++) begin
        if (g % 3 == 2) fill_random(100, 127);
        else fill_random(-128, 127);
        send_pair(p == len - 1);
      end
      get_result(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
